// File: rtl/pwm_channel.sv
// One PWM channel: bus-mapped CTRL/PERIOD/COMPARE/COUNT registers, prescaled
// up-counter with double-buffered period/compare and a registered PWM output.
module pwm_channel #(
    parameter int CNT_WIDTH   = 16,
    parameter int PRESC_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic        gnt,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        pwm_out,
    output logic        pwm_active,
    output logic        irq
);

    logic                   en;
    logic                   pol;
    logic                   irq_en;
    logic                   irq_pend;
    logic [PRESC_WIDTH-1:0] presc;
    logic [PRESC_WIDTH-1:0] presc_cnt;
    logic [CNT_WIDTH-1:0]   period_sh;
    logic [CNT_WIDTH-1:0]   compare_sh;
    logic [CNT_WIDTH-1:0]   period_act;
    logic [CNT_WIDTH-1:0]   cmp_act;
    logic [CNT_WIDTH-1:0]   cnt;

    logic [31:0] byte_mask;
    logic [31:0] ctrl_word;
    logic [31:0] period_word;
    logic [31:0] compare_word;
    logic [31:0] count_word;
    logic [31:0] merged_ctrl;
    logic [31:0] merged_period;
    logic [31:0] merged_compare;
    logic [31:0] merged_count;
    logic [31:0] rd_word;

    logic wr_ctrl;
    logic wr_period;
    logic wr_compare;
    logic wr_count;
    logic w1c_pend;
    logic tick;
    logic wrap;
    logic unused_bits;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_mask
            assign byte_mask[gi*8 +: 8] = {8{be[gi]}};
        end
    endgenerate

    assign ctrl_word    = 32'({presc, 4'b0000, irq_pend, irq_en, pol, en});
    assign period_word  = 32'(period_sh);
    assign compare_word = 32'(compare_sh);
    assign count_word   = 32'(cnt);

    assign merged_ctrl    = (ctrl_word    & ~byte_mask) | (wdata & byte_mask);
    assign merged_period  = (period_word  & ~byte_mask) | (wdata & byte_mask);
    assign merged_compare = (compare_word & ~byte_mask) | (wdata & byte_mask);
    assign merged_count   = (count_word   & ~byte_mask) | (wdata & byte_mask);

    assign wr_ctrl    = req && we && (addr[3:2] == 2'd0);
    assign wr_period  = req && we && (addr[3:2] == 2'd1);
    assign wr_compare = req && we && (addr[3:2] == 2'd2);
    assign wr_count   = req && we && (addr[3:2] == 2'd3);
    assign w1c_pend   = wr_ctrl && be[0] && wdata[3];

    // A counter pushed past period_act by a COUNT write only wraps on overflow.
    assign tick = en && (presc_cnt == presc);
    assign wrap = tick && ((cnt == period_act) || (&cnt));

    assign gnt        = req;
    assign pwm_active = en;
    assign irq        = irq_pend & irq_en;

    assign unused_bits = ^{addr[1:0], merged_ctrl, merged_period, merged_compare, merged_count};

    always_comb begin
        rd_word = '0;
        case (addr[3:2])
            2'd0:    rd_word = ctrl_word;
            2'd1:    rd_word = period_word;
            2'd2:    rd_word = compare_word;
            default: rd_word = count_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en         <= 1'b0;
            pol        <= 1'b0;
            irq_en     <= 1'b0;
            irq_pend   <= 1'b0;
            presc      <= '0;
            presc_cnt  <= '0;
            period_sh  <= '0;
            compare_sh <= '0;
            period_act <= '0;
            cmp_act    <= '0;
            cnt        <= '0;
            rvalid     <= 1'b0;
            rdata      <= '0;
            pwm_out    <= 1'b0;
        end else begin
            rvalid  <= req;
            rdata   <= (req && !we) ? rd_word : '0;
            pwm_out <= en ? ((cnt < cmp_act) ^ pol) : pol;

            if (!en) begin
                presc_cnt <= '0;
                cnt       <= '0;
            end else if (wr_count) begin
                presc_cnt <= '0;
                cnt       <= merged_count[CNT_WIDTH-1:0];
            end else if (tick) begin
                presc_cnt <= '0;
                cnt       <= wrap ? '0 : cnt + 1'b1;
            end else begin
                presc_cnt <= presc_cnt + 1'b1;
            end

            if (wrap) begin
                irq_pend <= 1'b1;
            end else if (w1c_pend) begin
                irq_pend <= 1'b0;
            end

            if (wr_ctrl) begin
                en     <= merged_ctrl[0];
                pol    <= merged_ctrl[1];
                irq_en <= merged_ctrl[2];
                presc  <= merged_ctrl[8 +: PRESC_WIDTH];
            end

            if (wr_period) begin
                period_sh <= merged_period[CNT_WIDTH-1:0];
            end
            // Shadow writes while idle or in the wrap cycle go straight to the active copy.
            if (wr_period && (!en || wrap)) begin
                period_act <= merged_period[CNT_WIDTH-1:0];
            end else if (wrap) begin
                period_act <= period_sh;
            end

            if (wr_compare) begin
                compare_sh <= merged_compare[CNT_WIDTH-1:0];
            end
            if (wr_compare && (!en || wrap)) begin
                cmp_act <= merged_compare[CNT_WIDTH-1:0];
            end else if (wrap) begin
                cmp_act <= compare_sh;
            end
        end
    end

endmodule

// File: tb/tb_pwm_channel.sv
// Bench for pwm_channel: directed scenarios with literal expectations, then
// randomized bus traffic checked every cycle against a behavioural model.
module tb_pwm_channel;

    localparam int CW   = 16;
    localparam int PW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [3:0]  addr = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        pwm_out;
    logic        pwm_active;
    logic        irq;

    int checks = 0;
    int failures = 0;
    bit cmp_on = 1'b0;

    // Model state
    int m_en, m_pol, m_irqen, m_pend, m_presc, m_pc;
    int m_period, m_compare, m_pact, m_cact, m_cnt;
    int m_rvalid, m_pwm;
    logic [31:0] m_rdata;

    always #5 clk = ~clk;

    pwm_channel #(.CNT_WIDTH(CW), .PRESC_WIDTH(PW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be), .addr(addr),
        .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .pwm_out(pwm_out), .pwm_active(pwm_active), .irq(irq)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (b[i]) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] reg_word(input logic [1:0] idx);
        case (idx)
            2'd0:    return 32'(m_en + 2*m_pol + 4*m_irqen + 8*m_pend + 256*m_presc);
            2'd1:    return 32'(m_period);
            2'd2:    return 32'(m_compare);
            default: return 32'(m_cnt);
        endcase
    endfunction

    // Next state from the register-level rules, evaluated at each rising edge.
    task automatic model_step();
        int n_en, n_pol, n_irqen, n_presc, n_pc, n_cnt, n_pend;
        int n_period, n_compare, n_pact, n_cact;
        bit tick, wrap, w1c;
        logic [31:0] wm;
        if (!rst_n) begin
            m_en = 0; m_pol = 0; m_irqen = 0; m_pend = 0; m_presc = 0; m_pc = 0;
            m_period = 0; m_compare = 0; m_pact = 0; m_cact = 0; m_cnt = 0;
            m_rvalid = 0; m_rdata = 0; m_pwm = 0;
            return;
        end
        tick = (m_en != 0) && (m_pc == m_presc);
        wrap = tick && ((m_cnt == m_pact) || (m_cnt == CMAX));
        w1c  = 0;
        n_en = m_en; n_pol = m_pol; n_irqen = m_irqen; n_presc = m_presc;
        n_period = m_period; n_compare = m_compare;
        n_pact = wrap ? m_period : m_pact;
        n_cact = wrap ? m_compare : m_cact;
        if (m_en == 0) begin
            n_pc = 0; n_cnt = 0;
        end else if (tick) begin
            n_pc = 0;
            n_cnt = wrap ? 0 : (m_cnt + 1) % (CMAX + 1);
        end else begin
            n_pc = m_pc + 1; n_cnt = m_cnt;
        end
        if (req && we) begin
            case (addr[3:2])
                2'd0: begin
                    wm = merge(reg_word(2'd0), wdata, be);
                    n_en = int'(wm[0]); n_pol = int'(wm[1]); n_irqen = int'(wm[2]);
                    n_presc = int'(wm[15:8]);
                    w1c = be[0] && wdata[3];
                end
                2'd1: begin
                    wm = merge(32'(m_period), wdata, be);
                    n_period = int'(wm[15:0]);
                    if (m_en == 0 || wrap) n_pact = n_period;
                end
                2'd2: begin
                    wm = merge(32'(m_compare), wdata, be);
                    n_compare = int'(wm[15:0]);
                    if (m_en == 0 || wrap) n_cact = n_compare;
                end
                default: begin
                    wm = merge(32'(m_cnt), wdata, be);
                    if (m_en != 0) begin
                        n_cnt = int'(wm[15:0]); n_pc = 0;
                    end
                end
            endcase
        end
        n_pend   = wrap ? 1 : (w1c ? 0 : m_pend);
        m_rvalid = int'(req);
        m_rdata  = (req && !we) ? reg_word(addr[3:2]) : 32'h0;
        m_pwm    = (m_en != 0) ? int'((m_cnt < m_cact) != (m_pol != 0)) : m_pol;
        m_en = n_en; m_pol = n_pol; m_irqen = n_irqen; m_presc = n_presc;
        m_pc = n_pc; m_cnt = n_cnt; m_pend = n_pend;
        m_period = n_period; m_compare = n_compare; m_pact = n_pact; m_cact = n_cact;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_on) begin
                check("gnt", gnt, req);
                check("rvalid", rvalid, m_rvalid);
                check("rdata", rdata, m_rdata);
                check("pwm_out", pwm_out, m_pwm);
                check("pwm_active", pwm_active, m_en);
                check("irq", irq, m_pend & m_irqen);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic bus_read(input int a, output logic [31:0] d);
        req = 1'b1; we = 1'b0; addr = a[3:0]; be = 4'h0; wdata = 32'h0;
        @(posedge clk); #1;
        req = 1'b0;
        check("read_rvalid", rvalid, 1);
        d = rdata;
    endtask

    task automatic bus_write(input int a, input logic [31:0] d, input logic [3:0] b);
        req = 1'b1; we = 1'b1; addr = a[3:0]; be = b; wdata = d;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
        check("write_rvalid", rvalid, 1);
        check("write_rdata", rdata, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic count_high(input int n, output int h);
        h = 0;
        repeat (n) begin
            @(posedge clk); #1;
            h += int'(pwm_out);
        end
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] seq[12];
        logic [31:0] junk;
        int h, found, seen_wrap, r;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cmp_on = 1'b1;

        // Reset state
        for (int a = 0; a < 4; a++) begin
            bus_read(a * 4, v);
            check("reset_read", v, 0);
        end
        check("reset_pwm", pwm_out, 0);
        check("reset_irq", irq, 0);
        check("model_reset_cnt", m_cnt, 0);

        // 3 high / 7 low
        bus_write(4, 32'd9, 4'hF);
        bus_write(8, 32'd3, 4'hF);
        bus_write(0, 32'h1, 4'hF);
        idle(3);
        count_high(30, h);
        check("duty_3_of_10", h, 9);

        seen_wrap = 0;
        for (int i = 0; i < 12; i++) bus_read(12, seq[i]);
        for (int i = 1; i < 12; i++) begin
            check("count_seq", seq[i], (seq[i-1] + 1) % 10);
            if (seq[i-1] == 9 && seq[i] == 0) seen_wrap = 1;
        end
        check("count_wrap_9_0", seen_wrap, 1);

        // Prescaler of 2
        bus_write(0, 32'h101, 4'hF);
        idle(25);
        count_high(40, h);
        check("presc1_duty", h, 12);

        // Mid-period compare change
        bus_write(0, 32'h1, 4'hF);
        idle(12);
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            v[0] = pwm_out;
            @(posedge clk); #1;
            if (!v[0] && pwm_out) found = 1;
        end
        check("rise_found", found, 1);
        h = 1;
        bus_write(8, 32'd7, 4'hF);
        h += int'(pwm_out);
        count_high(8, r);
        check("old_period_high", h + r, 3);
        count_high(10, h);
        check("new_period_high", h, 7);

        // Interrupts
        bus_write(8, 32'd3, 4'hF);
        for (int i = 0; i < 3; i++) begin
            bus_write(0, 32'hD, 4'hF);
            if (irq == 1'b0) break;
        end
        check("irq_cleared_first", irq, 0);
        found = 0;
        for (int i = 0; i < 25 && found == 0; i++) begin
            @(posedge clk); #1;
            if (irq) found = 1;
        end
        check("irq_rise", found, 1);
        bus_read(12, v);
        check("irq_after_wrap_cnt", v, 0);
        bus_write(0, 32'hD, 4'hF);
        check("irq_w1c", irq, 0);
        found = 0;
        for (int i = 0; i < 25 && found == 0; i++) begin
            @(posedge clk); #1;
            if (irq) found = 1;
        end
        check("irq_rise2", found, 1);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            bus_read(12, v);
            if (v == 8) found = 1;
        end
        check("count_reached_8", found, 1);
        bus_write(0, 32'hD, 4'hF);
        check("irq_w1c_vs_wrap", irq, 1);
        bus_write(0, 32'h9, 4'hF);
        check("irq_disabled", irq, 0);

        // Edge values
        bus_write(8, 32'd0, 4'hF);
        idle(12);
        count_high(25, h);
        check("compare0_low", h, 0);
        bus_write(8, 32'd10, 4'hF);
        idle(12);
        count_high(25, h);
        check("compare10_high", h, 25);
        bus_write(8, 32'd3, 4'hF);
        bus_write(0, 32'h3, 4'hF);
        idle(12);
        count_high(30, h);
        check("pol_inverted", h, 21);
        bus_write(0, 32'h2, 4'hF);
        idle(2);
        count_high(20, h);
        check("idle_pol1", h, 20);
        check("active_off", pwm_active, 0);
        bus_write(0, 32'h0, 4'hF);
        idle(2);
        count_high(20, h);
        check("idle_pol0", h, 0);

        // period_act = 0
        bus_write(4, 32'd0, 4'hF);
        bus_write(8, 32'd1, 4'hF);
        bus_write(0, 32'h1, 4'hF);
        idle(3);
        count_high(20, h);
        check("period0_high", h, 20);
        bus_read(12, v);
        check("period0_cnt", v, 0);

        // Reset mid-period, with a read pending
        bus_write(4, 32'd9, 4'hF);
        bus_write(8, 32'd5, 4'hF);
        idle(13);
        rst_n = 1'b0; req = 1'b1; we = 1'b0; addr = 4'hC;
        @(posedge clk); #1;
        rst_n = 1'b1; req = 1'b0;
        check("rst_pwm", pwm_out, 0);
        check("rst_rvalid", rvalid, 0);
        bus_read(12, v);
        check("rst_count", v, 0);
        bus_read(0, v);
        check("rst_ctrl", v, 0);

        // Randomized traffic
        bus_write(4, 32'd9, 4'hF);
        bus_write(8, 32'd4, 4'hF);
        bus_write(0, 32'h5, 4'hF);
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 99);
            junk = $urandom;
            we = junk[4];
            addr = 4'($urandom_range(0, 15));
            be = ($urandom_range(0, 9) < 7) ? 4'hF : 4'($urandom_range(0, 15));
            wdata = $urandom;
            case (addr[3:2])
                2'd0: begin
                    wdata[15:8] = 8'($urandom_range(0, 3));
                    wdata[0] = ($urandom_range(0, 9) < 8);
                end
                2'd1: wdata[15:0] = 16'($urandom_range(0, 15));
                2'd2: wdata[15:0] = 16'($urandom_range(0, 18));
                default: wdata[15:0] = junk[0] ? 16'($urandom_range(0, 20))
                                               : 16'($urandom_range(65530, 65535));
            endcase
            rst_n = (r >= 1);
            req = (r < 40);
            @(posedge clk); #1;
        end
        rst_n = 1'b1; req = 1'b0; we = 1'b0;
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_channel.md
Name: pwm_channel

Overview:
- One PWM channel behind the PWM address region (0x1B003000–0x1B003FFF). The SoC instantiates PWM_MODULE_COUNT=6 copies.
- The upstream bus decoder selects the channel and presents a 4-bit local byte address.
- The channel holds its own configuration registers and a prescaled up-counter. Its output drives one GPIO pin when that pin is in PWM mode.
- Period and compare values are double-buffered, so duty-cycle changes never glitch mid-period.

Parameters:
- CNT_WIDTH, 16, width of counter, period and compare registers.
- PRESC_WIDTH, 8, width of the prescaler field and prescaler counter.

Ports:
- clk  input  1  main system clock.
- rst_n  input  1  synchronous active-low reset.
- req  input  1  bus request, channel selected by decoder.
- we  input  1  1 = write, 0 = read.
- be  input  4  byte enables for the write.
- addr  input  4  local byte address, word aligned; addr[1:0] ignored.
- wdata  input  32  write data.
- gnt  output  1  grant; equals req combinationally, so there are no wait states.
- rvalid  output  1  response valid, exactly 1 cycle after a granted req.
- rdata  output  32  read data; valid only when rvalid=1, else 0.
- pwm_out  output  1  PWM waveform to GPIO mux.
- pwm_active  output  1  equals CTRL.EN; GPIO mux uses it for status.
- irq  output  1  level interrupt, equals IRQ_PEND & IRQ_EN.

Behaviour:
- Registers (word offsets):
  - 0x0 CTRL: bit0 EN, bit1 POL, bit2 IRQ_EN, bit3 IRQ_PEND (write-1-to-clear), bits[8+PRESC_WIDTH-1:8] PRESC.
  - 0x4 PERIOD: period shadow.
  - 0x8 COMPARE: compare shadow.
  - 0xC COUNT: counter; writes are allowed.
  - Unused bits read 0.
- Bus timing:
  - Accepted access at cycle N produces rvalid=1 at N+1 (peripheral latency 0 +1 inherent).
  - Writes take effect at the same edge as the accepted access (N); rvalid still pulses, with rdata=0.
  - Reads return the register value sampled at cycle N. Back-to-back requests are supported, one per cycle.
  - Byte enables apply per byte.
  - Unmapped or out-of-range bits: reads return 0, writes are ignored.
- Reset (rst_n=0 at a rising edge):
  - All registers, counter, prescaler, active copies, rvalid, rdata, pwm_out and irq go to 0.
  - Reset mid-period aborts the period immediately.
  - A pending response is dropped, so rvalid=0 on the following cycle.
- Counting with EN=1:
  - The prescaler counts 0..PRESC. When prescaler==PRESC it emits a tick and returns to 0, so PRESC=0 gives a tick every cycle.
  - On a tick, if cnt==period_act: cnt←0, period_act←PERIOD, cmp_act←COMPARE, IRQ_PEND←1.
  - On a tick otherwise: cnt←cnt+1.
- Output:
  - raw = (cnt < cmp_act); pwm_out = raw XOR POL, registered (1-cycle delay from cnt).
  - cmp_act=0 gives constant inactive; cmp_act > period_act gives constant active.
  - period_act=0: cnt stays 0, every tick is a wrap, output = (cmp_act≠0).
- EN=0:
  - Prescaler and cnt are held at 0; pwm_out = POL (idle level).
  - Writes to PERIOD/COMPARE also load period_act/cmp_act immediately.
- Enable transition: on EN 0→1, counting starts from cnt=0, prescaler=0, with the current active values.
- COUNT write: sets cnt directly (truncated to CNT_WIDTH) and resets the prescaler. It has priority over the same-cycle tick increment.
- A COUNT write above period_act does not wrap until cnt overflows to 0 naturally at 2^CNT_WIDTH. At that overflow, shadows load and IRQ_PEND sets.
- Simultaneous events:
  - Hardware setting IRQ_PEND wins over a same-cycle W1C.
  - A PERIOD/COMPARE write in the wrap cycle: the new value is loaded into the active copy (write data forwarded).
- irq is combinational from the registers: irq = IRQ_PEND & IRQ_EN.

Test Plan:
- Reset, then read all four registers: each rvalid exactly 1 cycle after req, rdata=0; pwm_out=0, irq=0.
- PERIOD=9, COMPARE=3, PRESC=0, EN=1: pwm_out is high 3 cycles / low 7 cycles, repeating every 10 cycles; COUNT read sequence wraps 9→0.
- Same settings with PRESC=1: period becomes 20 cycles with 6 cycles high.
- Mid-period write COMPARE=7: current period keeps 3 high; the next period shows 7 high; no runt pulses.
- IRQ_EN=1:
  - irq rises the cycle after the first wrap.
  - Writing CTRL with bit3=1 clears it.
  - When the W1C coincides with a wrap, irq stays 1.
- Edge values:
  - COMPARE=0 gives constant low.
  - COMPARE=10 with PERIOD=9 gives constant high.
  - POL=1 inverts the output.
  - EN=0 gives a constant POL level.
  - Asserting rst_n=0 mid-period gives pwm_out=0 and COUNT=0 next cycle.
